// File: rtl/packet_tx_builder.sv
// Builds a header+payload packet from a one-cycle request and streams it MSB-first, one byte per valid/ready handshake.
// B0 appears the cycle after accept; tx_ready low holds byte, tx_last and index; FIN pulses done before returning to IDLE.
module packet_tx_builder (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [2:0]  pktType,
  input  logic [15:0] myNodeID,
  input  logic [15:0] destinationID,
  input  logic [63:0] payload,
  output logic        busy,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  typedef struct packed {
    logic [2:0]  typ;
    logic [15:0] src;
    logic [15:0] dst;
    logic [63:0] pl;
  } hdr_t;

  state_t     state;
  hdr_t       pkt;
  logic [3:0] idx;
  logic [3:0] last_idx;

  function automatic logic [3:0] pkt_len(input logic [2:0] t);
    case (t)
      3'b000:         pkt_len = 4'd13;
      3'b001, 3'b100: pkt_len = 4'd7;
      default:        pkt_len = 4'd9;
    endcase
  endfunction

  // Full 13-byte image; short packets simply stop before the unused payload words.
  function automatic logic [7:0] pkt_byte(input hdr_t h, input logic [3:0] k);
    logic [103:0] flat;
    flat = {h.typ, 5'b0, h.src, h.dst, h.pl};
    flat = flat << {k, 3'b000};
    pkt_byte = flat[103:96];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pkt      <= '0;
      idx      <= '0;
      last_idx <= '0;
      busy     <= 1'b0;
      tx_valid <= 1'b0;
      tx_byte  <= '0;
      tx_last  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (pktType == 3'b111) begin
              err <= 1'b1;
            end else begin
              pkt      <= '{typ: pktType, src: myNodeID, dst: destinationID, pl: payload};
              last_idx <= pkt_len(pktType) - 4'd1;
              idx      <= '0;
              state    <= SEND;
              busy     <= 1'b1;
              tx_valid <= 1'b1;
              tx_byte  <= {pktType, 5'b0};
              tx_last  <= 1'b0;
            end
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (idx == last_idx) begin
              state    <= FIN;
              tx_valid <= 1'b0;
              tx_byte  <= '0;
              tx_last  <= 1'b0;
              done     <= 1'b1;
            end else begin
              idx     <= idx + 4'd1;
              tx_byte <= pkt_byte(pkt, idx + 4'd1);
              tx_last <= ((idx + 4'd1) == last_idx);
            end
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          tx_valid <= 1'b0;
          tx_byte  <= '0;
          tx_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packet_tx_builder.sv
// Directed bench for packet_tx_builder: table of packets plus hand sequences for reset, illegal type and back-to-back.
module tb_packet_tx_builder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [2:0]  pktType = '0;
  logic [15:0] myNodeID = '0;
  logic [15:0] destinationID = '0;
  logic [63:0] payload = '0;
  logic        busy, tx_valid, tx_last, done, err;
  logic [7:0]  tx_byte;
  logic        tx_ready = 1'b1;

  int n_checks = 0;
  int n_fail = 0;

  packet_tx_builder dut (
    .clk(clk), .rst(rst), .req(req), .pktType(pktType), .myNodeID(myNodeID),
    .destinationID(destinationID), .payload(payload), .busy(busy),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_last(tx_last),
    .tx_ready(tx_ready), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   typ;
    logic [15:0]  id;
    logic [15:0]  dst;
    logic [63:0]  pl;
    int           len;
    logic [103:0] exp;   // expected bytes, right-aligned, first byte most significant
    int           mode;  // 0: ready always, 1: ready 1,0,0 repeating, 2: ready 0,1 repeating
    bit           intrude;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int got;
    int cyc;
    logic [7:0] eb;
    pktType = v.typ; myNodeID = v.id; destinationID = v.dst; payload = v.pl;
    req = 1'b1;
    tick();
    req = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    got = 0;
    cyc = 0;
    while (got < v.len && cyc < 100) begin
      if (v.intrude && cyc == 2) begin
        req = 1'b1; pktType = 3'd1; myNodeID = ~v.id; destinationID = 16'hDEAD; payload = '1;
      end else begin
        req = 1'b0;
      end
      case (v.mode)
        1:       tx_ready = (cyc % 3 == 0);
        2:       tx_ready = (cyc % 2 == 1);
        default: tx_ready = 1'b1;
      endcase
      eb = v.exp[(v.len - 1 - got) * 8 +: 8];
      check("tx_valid_mid", 32'(tx_valid), 32'd1);
      check("tx_byte", 32'(tx_byte), 32'(eb));
      check("tx_last", 32'(tx_last), 32'(got == v.len - 1));
      if (tx_ready) got++;
      tick();
      cyc++;
    end
    check("bytes_sent_before_timeout", 32'(got), 32'(v.len));
    check("done_pulse", 32'(done), 32'd1);
    check("valid_in_fin", 32'(tx_valid), 32'd0);
    check("busy_in_fin", 32'(busy), 32'd1);
    tick();
    check("done_cleared", 32'(done), 32'd0);
    check("busy_cleared", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [19:0] b2b_pat;
    int waited;

    vecs[0] = '{3'd0, 16'h0012, 16'h0034, 64'h0001_0010_00F0_0080, 13,
                104'h00_0012_0034_0001_0010_00F0_0080, 0, 1'b0};
    vecs[1] = '{3'd4, 16'h0007, 16'h0008, 64'h0005_AAAA_BBBB_CCCC, 7,
                104'h80_0007_0008_0005, 1, 1'b0};
    vecs[2] = '{3'd5, 16'h1234, 16'h5678, 64'h0ABC_0DEF_1111_2222, 9,
                104'hA0_1234_5678_0ABC_0DEF, 0, 1'b0};
    vecs[3] = '{3'd3, 16'hFFFF, 16'h0001, 64'h8001_7FFE_1234_5678, 9,
                104'h60_FFFF_0001_8001_7FFE, 2, 1'b0};
    vecs[4] = '{3'd1, 16'h00AA, 16'h00BB, 64'hC0DE_1111_2222_3333, 7,
                104'h20_00AA_00BB_C0DE, 0, 1'b0};
    vecs[5] = '{3'd6, 16'h0102, 16'h0304, 64'h0506_0708_9999_8888, 9,
                104'hC0_0102_0304_0506_0708, 0, 1'b0};
    vecs[6] = '{3'd2, 16'h0A0B, 16'h0C0D, 64'h0011_0022_0033_0044, 9,
                104'h40_0A0B_0C0D_0011_0022, 0, 1'b1};

    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_tx_last", 32'(tx_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    run_vec(vecs[0]);
    run_vec(vecs[1]);

    // Illegal type 111: err pulse only, nothing starts.
    pktType = 3'd7; myNodeID = 16'h1111; destinationID = 16'h2222; req = 1'b1;
    tick();
    req = 1'b0;
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_busy", 32'(busy), 32'd0);
    check("illegal_valid", 32'(tx_valid), 32'd0);
    tick();
    check("illegal_err_clear", 32'(err), 32'd0);
    check("illegal_valid_after", 32'(tx_valid), 32'd0);
    run_vec(vecs[2]);

    run_vec(vecs[3]);

    // INV with an intruding request mid-flight: nothing queued afterwards.
    run_vec(vecs[6]);
    for (int i = 0; i < 3; i++) begin
      check("intrude_no_second_packet", 32'(tx_valid), 32'd0);
      check("intrude_no_extra_done", 32'(done), 32'd0);
      tick();
    end

    // Reset while the 4th SOS byte is on the bus.
    pktType = vecs[5].typ; myNodeID = vecs[5].id; destinationID = vecs[5].dst;
    payload = vecs[5].pl; tx_ready = 1'b1; req = 1'b1;
    tick();
    req = 1'b0;
    tick(); tick(); tick();
    check("sos_4th_byte", 32'(tx_byte), 32'h03);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(tx_valid), 32'd0);
    check("abort_byte", 32'(tx_byte), 32'd0);
    check("abort_last", 32'(tx_last), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    tick();
    check("abort_no_done_later", 32'(done), 32'd0);
    run_vec(vecs[4]);
    run_vec(vecs[5]);

    // Back-to-back CHE with req held: 7 valid cycles, FIN, IDLE accept, repeat.
    b2b_pat = 20'b11111110011111110011;
    pktType = 3'd1; myNodeID = 16'h00AA; destinationID = 16'h00BB;
    payload = 64'hC0DE_0000_0000_0000; tx_ready = 1'b1; req = 1'b1;
    tick();
    for (int c = 1; c <= 20; c++) begin
      check("b2b_valid", 32'(tx_valid), 32'(b2b_pat[20 - c]));
      if (c == 1 || c == 10 || c == 19) check("b2b_first_byte", 32'(tx_byte), 32'h20);
      if (c == 8 || c == 17) check("b2b_done", 32'(done), 32'd1);
      tick();
    end
    req = 1'b0;
    waited = 0;
    while (busy && waited < 40) begin
      tick();
      waited++;
    end
    check("b2b_drain_before_timeout", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
